alu_op_sequencer: RTL and testbench

- Front-end controller for the processor's combinational ALU.
- Accepts one RV32I OP, OP-IMM or BRANCH instruction plus its register operands over a valid/ready handshake.
- Decodes the instruction into the ALU's 4-bit opcode and drives the ALU operands.
- Registers the ALU result and flags, resolves branch conditions, and returns a response over a second valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: decodes RV32I OP/OP-IMM/BRANCH instructions,
// drives the ALU for one cycle, and returns the registered result.
module alu_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    input  logic             alu_z,
    input  logic             alu_of,
    input  logic             alu_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_z,
    output logic             flag_of,
    output logic             flag_n,
    output logic             branch_taken,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    state_t state_q, state_d;

    logic [31:0] a_q, b_q;
    logic [3:0]  op_q;
    logic        br_q;
    logic [2:0]  f3_q;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] shamt;
    logic [3:0]  dec_op;
    logic [31:0] dec_b;
    logic        dec_br;
    logic        dec_ill;
    logic        accept;
    logic        done;
    logic        cond;
    logic        unused_bits;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign shamt = {27'b0, instr[24:20]};
    assign unused_bits = ^{instr[11:7], instr[19:15]};

    always_comb begin
        dec_op  = OP_ADD;
        dec_b   = rs2_val;
        dec_br  = 1'b0;
        dec_ill = 1'b1;
        unique case (1'b1)
            (opc == OPC_OP): begin
                if (f7 == F7_ZERO) begin
                    dec_ill = 1'b0;
                    case (f3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000) begin
                        dec_op  = OP_SUB;
                        dec_ill = 1'b0;
                    end else if (f3 == 3'b101) begin
                        dec_op  = OP_SRA;
                        dec_ill = 1'b0;
                    end
                end
            end
            (opc == OPC_OPIMM): begin
                dec_b   = imm_i;
                dec_ill = 1'b0;
                case (f3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_b   = shamt;
                        dec_op  = OP_SLL;
                        dec_ill = (f7 != F7_ZERO);
                    end
                    default: begin
                        dec_b   = shamt;
                        dec_op  = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
                        dec_ill = (f7 != F7_ZERO) && (f7 != F7_ALT);
                    end
                endcase
            end
            (opc == OPC_BRANCH): begin
                dec_br  = 1'b1;
                dec_ill = 1'b0;
                case (f3)
                    3'b000, 3'b001: dec_op = OP_SUB;
                    3'b100, 3'b101: dec_op = OP_SLT;
                    3'b110, 3'b111: dec_op = OP_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign accept = (state_q == IDLE) && in_valid;
    assign done   = (state_q == RESP) && out_ready;

    // funct3[2] picks compare-bit vs zero flag; funct3[0] inverts the sense
    assign cond = (f3_q[2] ? alu_result[0] : alu_z) ^ f3_q[0];

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = 32'b0;
        alu_b      = 32'b0;
        alu_opcode = 4'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = dec_ill ? RESP : EXEC;
            end
            EXEC: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_opcode = op_q;
                state_d    = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= 32'b0;
            b_q          <= 32'b0;
            op_q         <= 4'b0;
            br_q         <= 1'b0;
            f3_q         <= 3'b0;
            result       <= 32'b0;
            flag_z       <= 1'b0;
            flag_of      <= 1'b0;
            flag_n       <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            op_count     <= '0;
        end else begin
            if (accept) begin
                a_q     <= rs1_val;
                b_q     <= dec_b;
                op_q    <= dec_op;
                br_q    <= dec_br;
                f3_q    <= f3;
                illegal <= dec_ill;
                if (dec_ill) begin
                    result       <= 32'b0;
                    flag_z       <= 1'b0;
                    flag_of      <= 1'b0;
                    flag_n       <= 1'b0;
                    branch_taken <= 1'b0;
                end
            end
            if (state_q == EXEC) begin
                result       <= br_q ? 32'b0 : alu_result;
                flag_z       <= alu_z;
                flag_of      <= alu_of;
                flag_n       <= alu_sign;
                branch_taken <= br_q & cond;
            end
            if (done)
                op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU hooked to
// its ALU port; vector table plus stall and mid-operation reset sequences.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr, rs1_val, rs2_val;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_z, alu_of, alu_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_z, flag_of, flag_n, branch_taken, illegal;
    logic [15:0] op_count;

    int nvec = 0;
    int nerr = 0;
    int exp_cnt = 0;

    alu_op_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_z(alu_z),
        .alu_of(alu_of), .alu_sign(alu_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_of(flag_of),
        .flag_n(flag_n), .branch_taken(branch_taken),
        .illegal(illegal), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // behavioural ALU
    always_comb begin
        alu_of = 1'b0;
        case (alu_opcode)
            4'b0000: begin
                alu_result = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) &&
                         (alu_result[31] != alu_a[31]);
            end
            4'b0001: begin
                alu_result = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) &&
                         (alu_result[31] != alu_a[31]);
            end
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = alu_a << alu_b[4:0];
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'b1000: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b1001: alu_result = {31'b0, alu_a < alu_b};
            default: alu_result = 32'b0;
        endcase
        alu_z    = (alu_result == 32'b0);
        alu_sign = alu_result[31];
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eb;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        of;
        logic        n;
        logic        tk;
        logic        ill;
        string       name;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = v.ins;
        rs1_val  = v.a;
        rs2_val  = v.b;
        check({v.name, " in_ready"}, 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!v.ill) begin
            check({v.name, " exec out_valid"}, 32'(out_valid), 0);
            check({v.name, " exec in_ready"}, 32'(in_ready), 0);
            check({v.name, " alu_opcode"}, 32'(alu_opcode), 32'(v.op));
            check({v.name, " alu_a"}, alu_a, v.a);
            check({v.name, " alu_b"}, alu_b, v.eb);
            @(posedge clk);
            #1;
        end else begin
            check({v.name, " alu_opcode"}, 32'(alu_opcode), 0);
            check({v.name, " alu_a"}, alu_a, 0);
            check({v.name, " alu_b"}, alu_b, 0);
        end
        check({v.name, " out_valid"}, 32'(out_valid), 1);
        check({v.name, " result"}, result, v.res);
        check({v.name, " flags"},
              32'({flag_z, flag_of, flag_n}), 32'({v.z, v.of, v.n}));
        check({v.name, " taken"}, 32'(branch_taken), 32'(v.tk));
        check({v.name, " illegal"}, 32'(illegal), 32'(v.ill));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        check({v.name, " op_count"}, 32'(op_count), exp_cnt);
        check({v.name, " idle out_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        vt[0]  = '{32'h0000_0033, 5, 7, 7, 4'h0, 12,
                   0, 0, 0, 0, 0, "ADD"};
        vt[1]  = '{32'h4000_0033, 32'h8000_0000, 1, 1, 4'h1,
                   32'h7FFF_FFFF, 0, 1, 0, 0, 0, "SUB_OF"};
        vt[2]  = '{32'h4000_0033, 9, 9, 9, 4'h1, 0,
                   1, 0, 0, 0, 0, "SUB_Z"};
        vt[3]  = '{32'h4040_5013, 32'hF000_0000, 0, 4, 4'h7,
                   32'hFF00_0000, 0, 0, 1, 0, 0, "SRAI"};
        vt[4]  = '{32'hFFF0_0013, 1, 0, 32'hFFFF_FFFF, 4'h0, 0,
                   1, 0, 0, 0, 0, "ADDI"};
        vt[5]  = '{32'h0000_4063, 32'hFFFF_FFFF, 1, 1, 4'h8, 0,
                   0, 0, 0, 1, 0, "BLT"};
        vt[6]  = '{32'h0000_6063, 32'hFFFF_FFFF, 1, 1, 4'h9, 0,
                   1, 0, 0, 0, 0, "BLTU"};
        vt[7]  = '{32'h0000_1063, 3, 3, 3, 4'h1, 0,
                   1, 0, 0, 0, 0, "BNE"};
        vt[8]  = '{32'h0000_0003, 5, 7, 0, 4'h0, 0,
                   0, 0, 0, 0, 1, "ILL_LOAD"};
        vt[9]  = '{32'h4000_4033, 5, 7, 0, 4'h0, 0,
                   0, 0, 0, 0, 1, "ILL_F7"};
        vt[10] = '{32'h0000_4033, 32'hF0F0_F0F0, 32'hFFFF_0000,
                   32'hFFFF_0000, 4'h4, 32'h0F0F_F0F0,
                   0, 0, 0, 0, 0, "XOR"};
        vt[11] = '{32'h01F0_1013, 1, 0, 31, 4'h5, 32'h8000_0000,
                   0, 0, 1, 0, 0, "SLLI"};
        vt[12] = '{32'h4000_1013, 1, 0, 0, 4'h0, 0,
                   0, 0, 0, 0, 1, "ILL_SLLI"};
        vt[13] = '{32'h0000_7063, 2, 1, 1, 4'h9, 0,
                   1, 0, 0, 1, 0, "BGEU"};
        vt[14] = '{32'h0000_2063, 2, 1, 0, 4'h0, 0,
                   0, 0, 0, 0, 1, "ILL_BR"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'b0;
        rs1_val   = 32'b0;
        rs2_val   = 32'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 1);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst result", result, 0);
        check("rst flags", 32'({flag_z, flag_of, flag_n,
              branch_taken, illegal}), 0);
        check("rst op_count", 32'(op_count), 0);
        check("rst alu", alu_a | alu_b | 32'(alu_opcode), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_vec(vt[i]);

        // response held under backpressure, new requests ignored
        @(negedge clk);
        in_valid = 1'b1;
        instr    = 32'h0000_0033;
        rs1_val  = 20;
        rs2_val  = 22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stall first out_valid", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = 32'h4000_0033;
            rs1_val  = 1;
            rs2_val  = 1;
            @(posedge clk);
            #1;
            check("stall out_valid", 32'(out_valid), 1);
            check("stall result", result, 42);
            check("stall in_ready", 32'(in_ready), 0);
            check("stall alu_opcode", 32'(alu_opcode), 0);
            check("stall op_count", 32'(op_count), exp_cnt);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
        check("stall release op_count", 32'(op_count), exp_cnt);
        check("stall release in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        check("stall no ghost op", 32'(out_valid), 0);

        // reset in EXEC aborts the operation
        @(negedge clk);
        in_valid  = 1'b1;
        instr     = 32'h0000_0033;
        rs1_val   = 3;
        rs2_val   = 4;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rstx exec opcode a", alu_a, 3);
        rst = 1'b1;
        #1;
        check("rstx out_valid", 32'(out_valid), 0);
        check("rstx in_ready", 32'(in_ready), 1);
        check("rstx result", result, 0);
        check("rstx alu", alu_a | alu_b | 32'(alu_opcode), 0);
        check("rstx op_count", 32'(op_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstx after out_valid", 32'(out_valid), 0);
        check("rstx after op_count", 32'(op_count), 0);
        out_ready = 1'b0;
        exp_cnt = 0;
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
